muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: iClk, input, 1, rising-edge clock; iRst, input, 1, synchronous active-high reset.
REQ-002 iStart, input, 1: request a new operation; sampled only in IDLE.
REQ-003 iOp, input, 2: operation select; 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
REQ-004 iRegA, input, 32: operand A (multiplicand or dividend), driven from register-file port A.
REQ-005 iRegB, input, 32: operand B (multiplier or divisor), driven from register-file port B.
REQ-006 iAddrC, input, 5: destination register address.
REQ-007 oBusy, output, 1: high while an operation is in flight, in both RUN and DONE.
REQ-008 oWrite, output, 1: one-cycle writeback strobe for the register-file write enable.
REQ-009 oAddrC, output, 5: captured destination address, valid while oWrite is high.
REQ-010 oRegC, output, 32: result, valid while oWrite is high.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE, an edge with iStart=1 SHALL accept the request:
- latch iOp, iRegA, iRegB and iAddrC;
- clear the 6-bit iteration counter;
- enter RUN.
REQ-013 After acceptance, input changes SHALL NOT affect the result.
REQ-014 iStart SHALL be ignored in RUN and DONE; no queuing.
REQ-015 RUN SHALL perform exactly one iteration per clock for 32 clocks, then enter DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-017 oWrite SHALL be 1 only in DONE, so it goes high in the cycle after the 32nd rising edge following the accepting edge.
REQ-018 Back-to-back throughput SHALL be one operation per 34 cycles, because a new request is accepted in the IDLE cycle after DONE.
REQ-019 MUL and MULHU SHALL use radix-2 unsigned shift-add on a 64-bit product; MUL returns product[31:0] and MULHU returns product[63:32].
REQ-020 DIVU and REMU SHALL use radix-2 unsigned restoring division with a 33-bit partial remainder.
REQ-021 Divide by zero SHALL produce DIVU = 0xFFFFFFFF and REMU = dividend, arising naturally from the algorithm with no exception.
REQ-022 A write to address 0 SHALL still pulse oWrite with oAddrC=0; the register file discards it.
REQ-023 oRegC and oAddrC SHALL hold their last values outside DONE.

Reset
REQ-024 When iRst=1 at a rising edge:
- state becomes IDLE;
- oBusy=0, oWrite=0;
- oRegC=32'h0, oAddrC=5'h0;
- counter and datapath registers are cleared.
REQ-025 Reset SHALL take priority over iStart on the same edge.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no oWrite pulse, and the next edge may accept a new start.

Configuration
REQ-027 With macro MULDIV_DIV_EN defined, all four operations SHALL behave as in Function.
REQ-028 Without MULDIV_DIV_EN, no divider hardware SHALL be built.
- DIVU/REMU requests go IDLE->DONE on the accepting edge.
- They produce oRegC=0 with oWrite high in the following cycle.
- MUL/MULHU are unchanged.

Verification
REQ-029 Test MUL.
- Stimulus: A=7, B=6, iAddrC=3, start.
- Required response: oBusy high next cycle; exactly one oWrite, 32 edges after acceptance, with oRegC=42 and oAddrC=3.
REQ-030 Test MULHU and MUL on the same operands.
- Stimulus: A=B=0xFFFFFFFF.
- Required response: MULHU gives 0xFFFFFFFE; MUL gives 0x00000001.
REQ-031 Test DIVU, REMU and divide by zero.
- Stimulus: A=100, B=7, then B=0.
- Required response: B=7 gives DIVU=14 and REMU=2; B=0 gives DIVU=0xFFFFFFFF and REMU=100.
REQ-032 Test start while busy.
- Stimulus: start MUL 3*5, then hold iStart=1 and change A to 9 during RUN.
- Required response: a single result of 15; the second op is accepted only after oBusy falls.
REQ-033 Test reset mid-operation.
- Stimulus: iRst at RUN iteration 10.
- Required response: no oWrite; all outputs 0; a fresh start of 2*2 yields 4.
REQ-034 Test build without MULDIV_DIV_EN.
- Stimulus: DIVU 100/7.
- Required response: oWrite the cycle after acceptance with oRegC=0; MUL 7*6 still returns 42 at 32 edges.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result bus between the issue stage and the iterative multiply/divide unit.
interface muldiv_unit_if;
    logic        iStart;
    logic [1:0]  iOp;
    logic [31:0] iRegA;
    logic [31:0] iRegB;
    logic [4:0]  iAddrC;
    logic        oBusy;
    logic        oWrite;
    logic [4:0]  oAddrC;
    logic [31:0] oRegC;

    modport master (output iStart, iOp, iRegA, iRegB, iAddrC,
                    input  oBusy, oWrite, oAddrC, oRegC);
    modport slave  (input  iStart, iOp, iRegA, iRegB, iAddrC,
                    output oBusy, oWrite, oAddrC, oRegC);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned MUL/MULHU (shift-add) and DIVU/REMU (restoring), 32 clocks per op.
// Define MULDIV_DIV_EN to build the divider; otherwise DIVU/REMU complete at once with result 0.
module muldiv_unit (
    input  logic          iClk,
    input  logic          iRst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;   // multiplicand for MUL*, divisor for DIV*
    logic [63:0] acc_q, acc_d;     // product, or dividend/quotient in the low half
    logic [4:0]  addr_q, addr_d;
    logic [31:0] regc_q, regc_d;
    logic [4:0]  addrc_q, addrc_d;
    logic        busy_q, busy_d;
    logic        write_q, write_d;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
`ifdef MULDIV_DIV_EN
    logic [31:0] rem_q, rem_d;
    logic [32:0] div_part_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;
    logic [31:0] quo_next_s;
    logic [31:0] rem_next_s;
`endif

    // One datapath iteration for each algorithm, evaluated from the current registers.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next_s = {mul_sum_s, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
        // The remainder stays below the divisor, so bit 32 of the difference is the borrow.
        div_part_s = {rem_q, acc_q[31]};
        div_diff_s = div_part_s - {1'b0, opnd_q};
        div_ge_s   = ~div_diff_s[32];
        quo_next_s = {acc_q[30:0], div_ge_s};
        rem_next_s = div_ge_s ? div_diff_s[31:0] : div_part_s[31:0];
`endif
    end

    // Next-state, operand capture and result selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        regc_d  = regc_q;
        addrc_d = addrc_q;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    op_d   = bus.iOp;
                    addr_d = bus.iAddrC;
                    cnt_d  = 6'd0;
`ifdef MULDIV_DIV_EN
                    rem_d  = 32'h0;
                    if (bus.iOp[1]) begin
                        opnd_d = bus.iRegB;
                        acc_d  = {32'h0, bus.iRegA};
                    end else begin
                        opnd_d = bus.iRegA;
                        acc_d  = {32'h0, bus.iRegB};
                    end
                    state_d = RUN;
`else
                    opnd_d = bus.iRegA;
                    acc_d  = {32'h0, bus.iRegB};
                    if (bus.iOp[1]) begin
                        state_d = DONE;
                        regc_d  = 32'h0;
                        addrc_d = bus.iAddrC;
                    end else begin
                        state_d = RUN;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    acc_d = {acc_q[63:32], quo_next_s};
                    rem_d = rem_next_s;
                end else begin
                    acc_d = mul_next_s;
                end
`else
                acc_d = mul_next_s;
`endif
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    addrc_d = addr_q;
                    case (op_q)
                        OP_MUL:   regc_d = mul_next_s[31:0];
                        OP_MULHU: regc_d = mul_next_s[63:32];
`ifdef MULDIV_DIV_EN
                        OP_DIVU:  regc_d = quo_next_s;
                        OP_REMU:  regc_d = rem_next_s;
`else
                        OP_DIVU:  regc_d = 32'h0;
                        OP_REMU:  regc_d = 32'h0;
`endif
                        default:  regc_d = 32'h0;
                    endcase
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        write_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'b00;
            opnd_q  <= 32'h0;
            acc_q   <= 64'h0;
            addr_q  <= 5'h0;
            regc_q  <= 32'h0;
            addrc_q <= 5'h0;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            regc_q  <= regc_d;
            addrc_q <= addrc_d;
            busy_q  <= busy_d;
            write_q <= write_d;
`ifdef MULDIV_DIV_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.oBusy  = busy_q;
    assign bus.oWrite = write_q;
    assign bus.oAddrC = addrc_q;
    assign bus.oRegC  = regc_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
`ifdef MULDIV_DIV_EN
            2'b10:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            2'b11:   return (b == 32'h0) ? a : a % b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Edges between the accepting edge and the edge that raises oWrite.
    function automatic int ref_latency(input logic [1:0] op);
`ifdef MULDIV_DIV_EN
        return (op == 2'b00) ? 32 : 32;
`else
        return op[1] ? 0 : 32;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expects the request already driven with iStart=1; the next rising edge accepts it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] addr, input bit hold);
        logic [31:0] exp_res;
        int          exp_lat;
        int          writes;
        int          seen_at;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op);
        writes  = 0;
        seen_at = -1;
        @(posedge clk);
        for (int n = 0; n <= exp_lat + 1; n++) begin
            @(negedge clk);
            if (n == 0) begin
                if (hold) begin
                    bus.iRegA = 32'd9;
                end else begin
                    bus.iStart = 1'b0;
                    bus.iOp    = 2'($urandom);
                    bus.iRegA  = $urandom;
                    bus.iRegB  = $urandom;
                    bus.iAddrC = 5'($urandom);
                end
                chk({tag, "_busy_after_accept"}, 32'(bus.oBusy), 32'd1);
            end
            if (bus.oWrite) begin
                writes++;
                if (seen_at < 0) begin
                    seen_at = n;
                    chk({tag, "_regc"}, bus.oRegC, exp_res);
                    chk({tag, "_addrc"}, 32'(bus.oAddrC), 32'(addr));
                end
            end
            if (n == exp_lat + 1) begin
                chk({tag, "_busy_idle"}, 32'(bus.oBusy), 32'd0);
                chk({tag, "_regc_hold"}, bus.oRegC, exp_res);
            end
        end
        chk({tag, "_write_count"}, 32'(writes), 32'd1);
        chk({tag, "_latency"}, 32'(seen_at), 32'(exp_lat));
    endtask

    task automatic start(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] addr);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = op;
        bus.iRegA  = a;
        bus.iRegB  = b;
        bus.iAddrC = addr;
        run_op(tag, op, a, b, addr, 1'b0);
    endtask

    initial begin
        int          writes;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.iStart = 1'b0;
        bus.iOp    = 2'b00;
        bus.iRegA  = 32'h0;
        bus.iRegB  = 32'h0;
        bus.iAddrC = 5'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.oBusy), 32'd0);
        chk("rst_write", 32'(bus.oWrite), 32'd0);
        chk("rst_regc", bus.oRegC, 32'h0);
        chk("rst_addrc", 32'(bus.oAddrC), 32'h0);
        rst = 1'b0;

        start("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3);
        chk("mul_7x6_const", bus.oRegC, 32'd42);
        start("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        chk("mulhu_max_const", bus.oRegC, 32'hFFFF_FFFE);
        start("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        chk("mul_max_const", bus.oRegC, 32'h0000_0001);

        start("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd6);
        start("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd7);
        start("divu_100_0", 2'b10, 32'd100, 32'd0, 5'd8);
        start("remu_100_0", 2'b11, 32'd100, 32'd0, 5'd9);
`ifdef MULDIV_DIV_EN
        chk("remu_100_0_const", bus.oRegC, 32'd100);
`else
        chk("remu_disabled_const", bus.oRegC, 32'd0);
        start("mul_after_div", 2'b00, 32'd7, 32'd6, 5'd10);
        chk("mul_after_div_const", bus.oRegC, 32'd42);
`endif

        start("mul_addr0", 2'b00, 32'd11, 32'd13, 5'd0);

        // Hold iStart through the whole op; the second request lands in the IDLE slot.
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b00;
        bus.iRegA  = 32'd3;
        bus.iRegB  = 32'd5;
        bus.iAddrC = 5'd12;
        run_op("busy_first", 2'b00, 32'd3, 32'd5, 5'd12, 1'b1);
        chk("busy_first_const", bus.oRegC, 32'd15);
        run_op("busy_second", 2'b00, 32'd9, 32'd5, 5'd12, 1'b0);

        // Reset at iteration 10, with iStart also high on the reset edge.
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b00;
        bus.iRegA  = 32'd1234;
        bus.iRegB  = 32'd5678;
        bus.iAddrC = 5'd21;
        @(posedge clk);
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (9) @(negedge clk);
        rst        = 1'b1;
        bus.iStart = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        bus.iStart = 1'b0;
        chk("rst_mid_busy", 32'(bus.oBusy), 32'd0);
        chk("rst_mid_write", 32'(bus.oWrite), 32'd0);
        chk("rst_mid_regc", bus.oRegC, 32'h0);
        chk("rst_mid_addrc", 32'(bus.oAddrC), 32'h0);
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.oWrite) writes++;
        end
        chk("rst_mid_no_write", 32'(writes), 32'd0);
        start("after_rst_2x2", 2'b00, 32'd2, 32'd2, 5'd1);
        chk("after_rst_2x2_const", bus.oRegC, 32'd4);

        for (int k = 0; k < 10; k++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            start("rand", rop, ra, rb, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
